// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: ramp command valid/ready channel
interface pwm_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_periods;
    modport master (output cmd_valid, cmd_target, cmd_step, cmd_periods, input cmd_ready);
    modport slave  (input cmd_valid, cmd_target, cmd_step, cmd_periods, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: steps an 8-bit PWM duty toward a commanded target on PWM period boundaries
module pwm_ramp_ctrl #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         PWM_FREQ   = 20_000,
    parameter logic [7:0] RESET_DUTY = 8'd0
) (
    input  logic             clk,
    input  logic             rst,
    pwm_ramp_ctrl_if.slave   cmd,
    input  logic             abort,
    output logic [7:0]       duty,
    output logic             period_tick,
    output logic             busy,
    output logic             done
);
    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int CW = $clog2(PERIOD);
    typedef enum logic {IDLE, RAMP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] duty_q, duty_d, tgt_q, tgt_d, stp_q, stp_d, per_q, per_d, div_q, div_d;
    logic done_q, done_d, tick, up;
    logic [8:0] diff, nxt;
    assign tick = cnt_q == CW'(PERIOD - 1);
    assign up = tgt_q > duty_q;
    assign diff = up ? {1'b0, tgt_q} - {1'b0, duty_q} : {1'b0, duty_q} - {1'b0, tgt_q};
    // a remaining distance within one step lands exactly on target, so no overshoot or wrap
    assign nxt = diff <= {1'b0, stp_q} ? {1'b0, tgt_q}
               : up ? {1'b0, duty_q} + {1'b0, stp_q} : {1'b0, duty_q} - {1'b0, stp_q};
    assign cmd.cmd_ready = state_q == IDLE;
    assign duty = duty_q;
    assign period_tick = tick;
    assign busy = state_q == RAMP;
    assign done = done_q;
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        duty_d = duty_q;
        tgt_d = tgt_q;
        stp_d = stp_q;
        per_d = per_q;
        div_d = div_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (cmd.cmd_valid) begin
                tgt_d = cmd.cmd_target;
                stp_d = cmd.cmd_step == 8'd0 ? 8'd1 : cmd.cmd_step;
                per_d = cmd.cmd_periods == 8'd0 ? 8'd1 : cmd.cmd_periods;
                div_d = per_d;
                if (cmd.cmd_target == duty_q) done_d = 1'b1;
                else state_d = RAMP;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (tick) begin
            if (div_q == 8'd1) begin
                div_d = per_q;
                duty_d = nxt[7:0];
                if (nxt[7:0] == tgt_q) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                end
            end else begin
                div_d = div_q - 8'd1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            duty_q <= RESET_DUTY;
            tgt_q <= '0;
            stp_q <= 8'd1;
            per_q <= 8'd1;
            div_q <= 8'd1;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            duty_q <= duty_d;
            tgt_q <= tgt_d;
            stp_q <= stp_d;
            per_q <= per_d;
            div_q <= div_d;
            done_q <= done_d;
        end
    end
endmodule
